// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM bus responder and the SRAM controller bench:
// FSM state encoding, error-bit positions and a saturating counter helper.
package sram_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_FILL  = 2'd1,
        ST_RD_DRIVE = 2'd2,
        ST_WR       = 2'd3
    } state_t;

    // Bit positions inside the sticky err vector.
    localparam int ERR_ADDR_CHG = 0;  // address moved during a write pulse
    localparam int ERR_WE_LONG  = 1;  // write pulse longer than MAX_WE_CYC

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read pipeline: DEPTH stages, each holding a sampled address and the data
// fetched for it. The last stage is what the responder drives onto the bus.
module sram_rd_pipe #(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Shift a new address/data pair in on every sample cycle; reset empties all stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (shift) begin
            addr_q[0] <= in_addr;
            data_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                addr_q[i] <= addr_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_addr = addr_q[DEPTH-1];
    assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/sram_bus_responder.sv
// Behavioural SRAM target on an asynchronous-style bus: reads are served
// READ_LAT cycles after the address is sampled, writes are captured while
// SRAM_WE_N is low and committed on the cycle it returns high.
//
// Bus ownership: the responder drives SRAM_DQ only in RD_DRIVE and only while
// SRAM_WE_N is high; the enable is combinational on SRAM_WE_N, so the instant
// the controller pulls SRAM_WE_N low the bus is released for its write data.
module sram_bus_responder
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 16,
    parameter int READ_LAT   = 1,
    parameter int MAX_WE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_WE_N,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic [1:0]        err,
    output logic [1:0]        state_dbg
);

    localparam logic [2:0] LAT3 = 3'(READ_LAT);
    localparam int WC_W = $clog2(MAX_WE_CYC + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WE_CYC);

    state_t state, state_next;
    logic [2:0] fill_q, fill_next, fill_inc;
    logic dq_oe, commit;

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [WC_W-1:0]   wr_cyc_q;
    logic [ADDR_W-1:0] pipe_addr, last_addr_q;
    logic [DATA_W-1:0] pipe_data, rd_data_in;
    logic              drove_q;
    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

    assign rd_idx   = SRAM_ADDR[DEPTH_LOG2-1:0];
    assign wr_idx   = wr_addr_q[DEPTH_LOG2-1:0];
    assign fill_inc = fill_q + 3'd1;

    // State register and fill counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            fill_q <= '0;
        end else begin
            state  <= state_next;
            fill_q <= fill_next;
        end
    end

    // Next state: any low SRAM_WE_N means a write; otherwise fill the pipe,
    // counting the sample taken on this edge, and drive once it is full.
    // With READ_LAT=1 the first sample already fills the pipe, so the fill
    // phase has zero length and the FSM goes straight to RD_DRIVE.
    always_comb begin
        state_next = state;
        fill_next  = fill_q;
        if (!SRAM_WE_N) begin
            state_next = ST_WR;
            fill_next  = '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_WR: begin
                    fill_next  = 3'd1;
                    state_next = (3'd1 >= LAT3) ? ST_RD_DRIVE : ST_RD_FILL;
                end
                ST_RD_FILL: begin
                    fill_next  = fill_inc;
                    state_next = (fill_inc >= LAT3) ? ST_RD_DRIVE : ST_RD_FILL;
                end
                ST_RD_DRIVE: begin
                    state_next = ST_RD_DRIVE;
                end
            endcase
        end
    end

    // Outputs: bus enable in RD_DRIVE, write commit on the first high cycle after WR.
    always_comb begin
        dq_oe  = 1'b0;
        commit = 1'b0;
        case (state)
            ST_RD_DRIVE: dq_oe  = SRAM_WE_N;
            ST_WR:       commit = SRAM_WE_N;
            default: ;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? pipe_data : {DATA_W{1'bz}};
    assign state_dbg = state;

    // A read sampled in the commit cycle of the same word sees the new data.
    assign rd_data_in = (commit && (wr_idx == rd_idx)) ? wr_data_q : mem[rd_idx];

    sram_rd_pipe #(
        .DEPTH (READ_LAT),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .shift   (SRAM_WE_N),
        .in_addr (SRAM_ADDR),
        .in_data (rd_data_in),
        .out_addr(pipe_addr),
        .out_data(pipe_data)
    );

    // Backing array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) mem[wr_idx] <= wr_data_q;
    end

    // Capture write address/data every low cycle and track pulse length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_cyc_q  <= '0;
        end else if (!SRAM_WE_N) begin
            wr_addr_q <= SRAM_ADDR;
            wr_data_q <= SRAM_DQ;
            if (state != ST_WR)        wr_cyc_q <= WC_W'(1);
            else if (wr_cyc_q < WC_MAX) wr_cyc_q <= wr_cyc_q + 1'b1;
        end
    end

    // Sticky protocol error flags, checked on each continuing write cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 2'b00;
        end else if (!SRAM_WE_N && (state == ST_WR)) begin
            if (SRAM_ADDR != wr_addr_q) err[ERR_ADDR_CHG] <= 1'b1;
            if (wr_cyc_q >= WC_MAX)     err[ERR_WE_LONG]  <= 1'b1;
        end
    end

    // Access counters; a read counts on the first drive cycle or on an address change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count    <= '0;
            wr_count    <= '0;
            drove_q     <= 1'b0;
            last_addr_q <= '0;
        end else begin
            if (commit) wr_count <= sat_inc(wr_count);
            if (dq_oe && (!drove_q || (pipe_addr != last_addr_q)))
                rd_count <= sat_inc(rd_count);
            drove_q <= dq_oe;
            if (dq_oe) last_addr_q <= pipe_addr;
        end
    end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder: one instance with READ_LAT=1 and one with
// READ_LAT=3 share the controller stimulus, each on its own data bus.
module tb_sram_bus_responder;
  import sram_bus_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] addr;
  logic          we_n;
  logic [DW-1:0] drive_val;
  logic          drive_a, drive_b;
  wire  [DW-1:0] dq_a, dq_b;
  logic [31:0]   rd_a, wr_a, rd_b, wr_b;
  logic [1:0]    err_a, err_b, st_a, st_b;

  assign dq_a = drive_a ? drive_val : {DW{1'bz}};
  assign dq_b = drive_b ? drive_val : {DW{1'bz}};

  sram_bus_responder #(.READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_WE_N(we_n), .SRAM_DQ(dq_a),
    .rd_count(rd_a), .wr_count(wr_a), .err(err_a), .state_dbg(st_a)
  );

  sram_bus_responder #(.READ_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_WE_N(we_n), .SRAM_DQ(dq_b),
    .rd_count(rd_b), .wr_count(wr_b), .err(err_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] rd_addr[8];
  logic [DW-1:0] rd_exp[8];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, got, want);
    end
  endtask

  task automatic push(input int which, input int c, input logic [DW-1:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    if (which == 1) exp_a.push_back(e);
    else            exp_b.push_back(e);
  endtask

  // Monitor: pops an entry whenever its cycle is reached and compares the bus.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_a.size() > 0 && exp_a[0].cyc <= cyc) begin
      e = exp_a.pop_front();
      if (e.cyc != cyc) begin
        vectors++; miscompares++;
        $display("FAIL dq_lat1 stale entry: got cycle %0d, want cycle %0d", cyc, e.cyc);
      end else cmp("dq_lat1", 32'(dq_a), 32'(e.data));
    end
    if (exp_b.size() > 0 && exp_b[0].cyc <= cyc) begin
      e = exp_b.pop_front();
      if (e.cyc != cyc) begin
        vectors++; miscompares++;
        $display("FAIL dq_lat3 stale entry: got cycle %0d, want cycle %0d", cyc, e.cyc);
      end else cmp("dq_lat3", 32'(dq_b), 32'(e.data));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] rd, input logic [31:0] wr,
                            input logic [1:0] e);
    cmp({tag, ".rd_count_lat1"}, rd_a, rd);
    cmp({tag, ".wr_count_lat1"}, wr_a, wr);
    cmp({tag, ".err_lat1"}, 32'(err_a), 32'(e));
    cmp({tag, ".rd_count_lat3"}, rd_b, rd);
    cmp({tag, ".wr_count_lat3"}, wr_b, wr);
    cmp({tag, ".err_lat3"}, 32'(err_b), 32'(e));
  endtask

  // Asynchronous reset: checked one time unit after assertion, before any edge.
  task automatic do_reset();
    rst = 1'b0;
    we_n = 1'b1;
    drive_a = 1'b0;
    drive_b = 1'b0;
    drive_val = '0;
    #1;
    cmp("reset.state_lat1", 32'(st_a), 32'(ST_IDLE));
    cmp("reset.state_lat3", 32'(st_b), 32'(ST_IDLE));
    check_regs("reset", 32'd0, 32'd0, 2'b00);
    step();
    step();
    rst = 1'b1;
  endtask

  // Write cycles: bench owns the bus, so both buses must carry exactly d.
  task automatic write_pulse(input logic [AW-1:0] a, input logic [DW-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      we_n = 1'b0;
      addr = a;
      drive_val = d;
      drive_a = 1'b1;
      drive_b = 1'b1;
      push(1, cyc, d);
      push(3, cyc, d);
      step();
    end
  endtask

  // Single high cycle between two write pulses (commit, nothing driven).
  task automatic gap();
    we_n = 1'b1;
    drive_a = 1'b0;
    drive_b = 1'b0;
    step();
  endtask

  // Read burst of n addresses followed by 3 cycles holding the last one.
  // During a responder's fill window the bench drives 0 as a release probe:
  // any responder drive would corrupt it.
  task automatic read_seq(input int n);
    int s;
    int len;
    int k;
    s = cyc;
    len = n + 3;
    for (int c = 0; c < len; c++) begin
      k = (c - 1 < n - 1) ? c - 1 : n - 1;
      push(1, s + c, (c < 1) ? 16'h0000 : rd_exp[k]);
      k = (c - 3 < n - 1) ? c - 3 : n - 1;
      push(3, s + c, (c < 3) ? 16'h0000 : rd_exp[k]);
    end
    for (int c = 0; c < len; c++) begin
      we_n = 1'b1;
      addr = rd_addr[(c < n) ? c : n - 1];
      drive_val = '0;
      drive_a = (c < 1);
      drive_b = (c < 3);
      step();
    end
    drive_a = 1'b0;
    drive_b = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    we_n = 1'b1;
    addr = '0;
    drive_val = '0;
    drive_a = 1'b0;
    drive_b = 1'b0;
    #2;
    do_reset();

    // Write 0xBEEF at 0x10 (2-cycle pulse), then read it back at once.
    write_pulse(18'h00010, 16'hBEEF, 2);
    rd_addr[0] = 18'h00010; rd_exp[0] = 16'hBEEF;
    read_seq(1);
    check_regs("wr_then_rd", 32'd1, 32'd1, 2'b00);

    // Turnaround from RD_DRIVE (bench drives 0xA5A5), then preload 0..3.
    write_pulse(18'h00030, 16'hA5A5, 1); gap();
    write_pulse(18'h00000, 16'h1111, 1); gap();
    write_pulse(18'h00001, 16'h2222, 1); gap();
    write_pulse(18'h00002, 16'h3333, 1); gap();
    write_pulse(18'h00003, 16'h4444, 1);
    rd_addr[0] = 18'h00000; rd_exp[0] = 16'h1111;
    rd_addr[1] = 18'h00001; rd_exp[1] = 16'h2222;
    rd_addr[2] = 18'h00002; rd_exp[2] = 16'h3333;
    rd_addr[3] = 18'h00003; rd_exp[3] = 16'h4444;
    rd_addr[4] = 18'h00030; rd_exp[4] = 16'hA5A5;
    read_seq(5);
    check_regs("b2b", 32'd6, 32'd6, 2'b00);

    // Address change mid-pulse: last captured pair (0x41, 0x0202) commits.
    write_pulse(18'h00040, 16'h0101, 1);
    write_pulse(18'h00041, 16'h0202, 1);
    gap();
    check_regs("addr_chg", 32'd6, 32'd7, 2'b01);

    // Exactly MAX_WE_CYC cycles is still legal.
    write_pulse(18'h00051, 16'h5151, 4);
    gap();
    check_regs("pulse4", 32'd6, 32'd8, 2'b01);

    // 6-cycle pulse is too long but still commits.
    write_pulse(18'h00050, 16'h5050, 6);
    rd_addr[0] = 18'h00041; rd_exp[0] = 16'h0202;
    rd_addr[1] = 18'h00050; rd_exp[1] = 16'h5050;
    rd_addr[2] = 18'h00051; rd_exp[2] = 16'h5151;
    read_seq(3);
    check_regs("pulse6", 32'd9, 32'd9, 2'b11);

    // Reset clears sticky errors; then reset during a write aborts it.
    do_reset();
    write_pulse(18'h00020, 16'h0000, 1);
    rd_addr[0] = 18'h00020; rd_exp[0] = 16'h0000;
    read_seq(1);
    check_regs("old20", 32'd1, 32'd1, 2'b00);
    write_pulse(18'h00020, 16'hDEAD, 1);
    do_reset();
    rd_addr[0] = 18'h00020; rd_exp[0] = 16'h0000;
    read_seq(1);
    check_regs("abort", 32'd1, 32'd0, 2'b00);

    // Address wrap: 0x10005 lands on word 5; 0x10 kept 0xBEEF across resets.
    write_pulse(18'h10005, 16'h7777, 1);
    rd_addr[0] = 18'h00010; rd_exp[0] = 16'hBEEF;
    rd_addr[1] = 18'h00005; rd_exp[1] = 16'h7777;
    read_seq(2);
    check_regs("wrap", 32'd3, 32'd1, 2'b00);

    step();
    step();

    // ---------------- final report ----------------
    while (exp_a.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL dq_lat1 unchecked: got none, want %h at cycle %0d", exp_a[0].data, exp_a[0].cyc);
      void'(exp_a.pop_front());
    end
    while (exp_b.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL dq_lat3 unchecked: got none, want %h at cycle %0d", exp_b[0].data, exp_b[0].cyc);
      void'(exp_b.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_bus_responder.md
SRAM_BUS_RESPONDER -- requirements
Module: sram_bus_responder

Interface
REQ-001 Parameter ADDR_W, default 18, width of SRAM_ADDR.
REQ-002 Parameter DATA_W, default 16, width of SRAM_DQ.
REQ-003 Parameter DEPTH_LOG2, default 16, log2 of backing-array words; higher address bits are ignored (address wraps modulo 2^DEPTH_LOG2).
REQ-004 Parameter READ_LAT, default 1, legal 1..4, cycles from address sample to DQ drive.
REQ-005 Parameter MAX_WE_CYC, default 4, longest legal write pulse in cycles.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-008 SRAM_ADDR  input  ADDR_W  word address from the SRAM controller.
REQ-009 SRAM_WE_N  input  1  write strobe, active-low.
REQ-010 SRAM_DQ  inout  DATA_W  bidirectional data bus.
REQ-011 rd_count  output  32  number of read accesses served.
REQ-012 wr_count  output  32  number of committed writes.
REQ-013 err  output  2  sticky protocol errors: bit0 address changed during write pulse, bit1 write pulse exceeded MAX_WE_CYC.

Function
REQ-014 State machine: IDLE, RD_FILL, RD_DRIVE, WR.
REQ-015 Transitions:
- IDLE -> RD_FILL when SRAM_WE_N=1; IDLE -> WR when SRAM_WE_N=0.
- RD_FILL -> RD_DRIVE once READ_LAT address samples are held.
- RD_FILL or RD_DRIVE -> WR when SRAM_WE_N=0.
- WR -> RD_FILL when SRAM_WE_N=1, with the fill counter cleared.
REQ-016 While SRAM_WE_N=1, SRAM_ADDR shall be sampled every cycle into a READ_LAT-deep address/data pipeline.
REQ-017 In RD_DRIVE, SRAM_DQ shall equal mem[address sampled READ_LAT cycles earlier].
REQ-018 In all other states, SRAM_DQ shall be high-Z.
REQ-019 SRAM_DQ shall be released combinationally in the same cycle SRAM_WE_N is 0, with no registered delay, so the bus never contends.
REQ-020 rd_count shall increment once per RD_DRIVE cycle in which the driven address differs from the previous driven address, or which is the first RD_DRIVE cycle after RD_FILL.
REQ-021 In WR, SRAM_ADDR and SRAM_DQ shall be captured every cycle.
REQ-022 On the first cycle SRAM_WE_N returns to 1, the last captured data shall be written to mem[last captured address], and wr_count shall increment by 1.
REQ-023 err[0] shall set when SRAM_ADDR differs between consecutive WR cycles.
REQ-024 err[1] shall set when WR persists for more than MAX_WE_CYC cycles.
REQ-025 Both error bits are sticky until reset, and the write still commits.
REQ-026 Counters saturate at 32'hFFFFFFFF and do not wrap.
REQ-027 A read of an address written in the immediately preceding commit cycle shall return the new data (write-before-read ordering).

Reset
REQ-028 On rst=0 the block shall immediately enter IDLE, tri-state SRAM_DQ, clear the pipeline and fill counter, and set rd_count=0, wr_count=0, err=2'b00.
REQ-029 Backing array contents are not reset.
REQ-030 Reset asserted during WR aborts the pulse, and no commit occurs.
REQ-031 Release of reset shall take effect on the first rising clk edge with rst=1.

Structure
REQ-032 State encoding and the error-bit index constants belong in a shared package, sram_bus_pkg, reused by the SRAM controller bench.
REQ-033 The read pipeline shall be one sub-module, sram_rd_pipe (parameterized depth READ_LAT, holding address plus data), instantiated once.

Verification
REQ-034 Write then read, READ_LAT=1:
- Stimulus: WE_N low 2 cycles at addr 0x00010 with DQ=0xBEEF, then WE_N high with addr 0x00010.
- Required: DQ=0xBEEF one cycle later, wr_count=1, rd_count=1.
REQ-035 READ_LAT=3, back-to-back reads:
- Stimulus: preload addrs 0..3 with 0x1111, 0x2222, 0x3333, 0x4444; present addrs 0,1,2,3 on consecutive cycles.
- Required: DQ high-Z for 3 cycles, then 0x1111..0x4444 on consecutive cycles; rd_count=4.
REQ-036 Turnaround:
- Stimulus: WE_N falls while in RD_DRIVE.
- Required: DQ high-Z in the same cycle; no X on the bus when the bench drives 0xA5A5.
REQ-037 Protocol errors:
- Stimulus: address changes mid-pulse; separately, a 6-cycle write pulse with MAX_WE_CYC=4.
- Required: err=2'b01, then err=2'b11; both writes commit; err remains set until reset.
REQ-038 Reset mid-write:
- Stimulus: rst=0 on WR cycle 2 at addr 0x00020 holding old value 0x0000.
- Required: DQ high-Z immediately; wr_count=0; a later read of 0x00020 returns 0x0000.
REQ-039 Address wrap:
- Stimulus: write 0x7777 to addr 0x10005 with DEPTH_LOG2=16.
- Required: a read of 0x00005 returns 0x7777.
